// File: rtl/multi_button_pulser_pkg.sv
// Shared types and helpers for the multi-channel button pulser.
package multi_button_pulser_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StRepeat
  } hold_state_t;

  // Counter width able to hold the value n.
  function automatic int unsigned cntw(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_pulser_channel.sv
// One button channel: two-flop synchroniser, debounce counter, hold FSM with auto-repeat timer.
module button_pulser_channel
  import multi_button_pulser_pkg::*;
#(
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic repeat_en_i,
  output logic press_o,
  output logic release_o,
  output logic level_o
);

  localparam int unsigned RMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned DW   = cntw(DEBOUNCE);
  localparam int unsigned RW   = cntw(RMax);

  localparam logic [DW-1:0] DebLast    = DW'(DEBOUNCE - 1);
  localparam logic [RW-1:0] DelayLast  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PeriodLast = RW'(REPEAT_PERIOD - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  hold_state_t   state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          rise, fall;

  always_comb begin
    s1_d    = btn_i;
    s2_d    = s1_q;
    dcnt_d  = '0;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (s2_q != level_q) begin
      if (dcnt_q == DebLast) begin
        level_d = s2_q;
        rise    = s2_q;
        fall    = ~s2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    // A release always takes priority over any repeat terminal count.
    if (fall) begin
      state_d   = StIdle;
      rcnt_d    = '0;
      release_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            press_d = 1'b1;
            state_d = StHeld;
            rcnt_d  = '0;
          end
        end
        StHeld: begin
          if (!repeat_en_i) begin
            rcnt_d = '0;
          end else if (rcnt_q == DelayLast) begin
            press_d = 1'b1;
            state_d = StRepeat;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        StRepeat: begin
          if (!repeat_en_i) begin
            state_d = StHeld;
            rcnt_d  = '0;
          end else if (rcnt_q == PeriodLast) begin
            press_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      state_q   <= StIdle;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign level_o   = level_q;

endmodule

// File: rtl/multi_button_pulser.sv
// Array of independent debounced button channels emitting press/release strobes.
module multi_button_pulser
  import multi_button_pulser_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] repeatEn,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] level
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_pulser_channel #(
      .DEBOUNCE     (DEBOUNCE),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk_i      (Clock),
      .rst_ni     (Reset_n),
      .btn_i      (in[g]),
      .repeat_en_i(repeatEn[g]),
      .press_o    (press[g]),
      .release_o  (release_o[g]),
      .level_o    (level[g])
    );
  end

endmodule
